spi_adc_reader: RTL and testbench

//  SPI master that reads one SAMPLE_WIDTH-bit word per sample period from the microphone ADC.

---
 rtl/spi_adc_reader.sv | 139 +++++++++++++
 tb/tb_spi_adc_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_reader.sv
// SPI master (CPOL=1, CPHA=1) that reads one SAMPLE_WIDTH-bit word per sample period from the
// microphone ADC and presents it on a valid/ready stream with a sticky overrun flag.
module spi_adc_reader #(
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned HALF_PERIOD   = 2,
  parameter int unsigned SAMPLE_PERIOD = 80
) (
  input  logic                    inclock,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    spi_clock,
  output logic                    spi_chipselect,
  input  logic                    spi_data,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned RW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned BW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [RW-1:0] RATE_LAST  = RW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(SAMPLE_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [RW-1:0]           rate_cnt;
  logic                    tick;
  logic [PW-1:0]           phase;
  logic                    phase_done;
  logic [BW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic                    capture;
  logic                    shift_en;
  logic                    bit_clr;
  logic                    bit_inc;

  assign tick       = (rate_cnt == RATE_LAST);
  assign phase_done = (phase == PHASE_LAST);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      rate_cnt <= '0;
    end else if (tick) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    shift_en   = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    case (state)
      S_IDLE:  if (tick && enable) state_next = S_SETUP;
      S_SETUP: if (phase_done) begin
        state_next = S_LOW;
        bit_clr    = 1'b1;
      end
      S_LOW:   if (phase_done) begin
        state_next = S_HIGH;
        shift_en   = 1'b1;
      end
      S_HIGH:  if (phase_done) begin
        if (bit_cnt == BIT_LAST) begin
          state_next = S_HOLD;
          capture    = 1'b1;
        end else begin
          state_next = S_LOW;
          bit_inc    = 1'b1;
        end
      end
      S_HOLD:  if (phase_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // SCLK/CS are decoded from the next state so the pins change on the same edge as the state.
  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      phase          <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      spi_clock      <= 1'b1;
      spi_chipselect <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], spi_data};
      end
      spi_clock      <= (state_next != S_LOW);
      spi_chipselect <= !(state_next inside {S_SETUP, S_LOW, S_HIGH});
    end
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (capture) begin
      sample_data  <= shift_reg;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Bench for spi_adc_reader: ADC pin model, frame-timing/stream reference model checked every cycle,
// a table of frames with fixed expectations, and hand sequences for reset and enable corner cases.
module tb_spi_adc_reader;

  localparam int unsigned W      = 16;
  localparam int unsigned H      = 2;
  localparam int unsigned P      = 80;
  localparam int unsigned CS_LEN = H * (2 * W + 1);
  localparam int unsigned BUSY_N = H * (2 * W + 2);

  logic         inclock = 1'b0;
  logic         reset;
  logic         enable;
  logic         spi_clock;
  logic         spi_chipselect;
  logic         spi_data;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready;
  logic         busy;
  logic         overrun;

  spi_adc_reader #(
    .SAMPLE_WIDTH (W),
    .HALF_PERIOD  (H),
    .SAMPLE_PERIOD(P)
  ) dut (
    .inclock       (inclock),
    .reset         (reset),
    .enable        (enable),
    .spi_clock     (spi_clock),
    .spi_chipselect(spi_chipselect),
    .spi_data      (spi_data),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 inclock = ~inclock;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc;

  always @(posedge inclock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ADC: loads the word when CS falls, drives MSB first on each SCLK fall.
  logic [W-1:0] adc_word = '0;
  logic [W-1:0] adc_sh;
  always @(negedge spi_chipselect or negedge spi_clock) begin
    if (spi_clock) begin
      adc_sh = adc_word;
    end else if (!spi_chipselect) begin
      spi_data = adc_sh[W-1];
      adc_sh   = {adc_sh[W-2:0], 1'b0};
    end
  end

  // Reference model state
  bit           m_active;
  int unsigned  m_start;
  logic [W-1:0] m_word;
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_ovr;
  int unsigned  rmode;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  task automatic step();
    int unsigned k;
    bit exp_cs;
    bit exp_sclk;
    @(negedge inclock);
    if (reset) begin
      m_active = 0; m_valid = 0; m_data = '0; m_ovr = 0;
    end else begin
      if (m_active && cyc - m_start >= BUSY_N) m_active = 0;
      if (!m_active && cyc != 0 && cyc % P == 0 && enable) begin
        m_active = 1; m_start = cyc; m_word = adc_word;
      end
      k = cyc - m_start;
      if (m_active && k == CS_LEN) begin
        if (m_valid && !sample_ready) m_ovr = 1;
        m_data  = m_word;
        m_valid = 1;
      end else if (m_valid && sample_ready) begin
        m_valid = 0;
      end
    end
    k        = cyc - m_start;
    exp_cs   = !(m_active && k < CS_LEN);
    exp_sclk = !(m_active && k >= H && k < CS_LEN && ((k - H) / H) % 2 == 0);
    chk("cs",      32'(spi_chipselect), 32'(exp_cs));
    chk("sclk",    32'(spi_clock),      32'(exp_sclk));
    chk("busy",    32'(busy),           32'(m_active));
    chk("valid",   32'(sample_valid),   32'(m_valid));
    chk("overrun", 32'(overrun),        32'(m_ovr));
    chk("data",    32'(sample_data),    32'(m_data));
    case (rmode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      2:       sample_ready = m_active && (k == CS_LEN - 1);
      default: sample_ready = 1'($urandom % 2);
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_async_cs",   32'(spi_chipselect), 32'd1);
    chk("rst_async_sclk", 32'(spi_clock),      32'd1);
    chk("rst_async_busy", 32'(busy),           32'd0);
    repeat (5) step();
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [W-1:0] w, input int unsigned mode);
    int unsigned falls = 0;
    int unsigned csl   = 0;
    int unsigned bsy   = 0;
    bit started = 0;
    bit done    = 0;
    logic prev_sclk;
    adc_word  = w;
    enable    = 1'b1;
    rmode     = mode;
    prev_sclk = spi_clock;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (prev_sclk && !spi_clock) falls++;
      prev_sclk = spi_clock;
      if (!spi_chipselect) csl++;
      if (busy) bsy++;
      if (m_active) started = 1;
      else if (started) done = 1;
    end
    chk("frame_done",  32'(done), 32'd1);
    chk("sclk_falls",  falls, W);
    chk("cs_low_len",  csl,   CS_LEN);
    chk("busy_len",    bsy,   BUSY_N);
  endtask

  typedef struct {
    bit          rst_before;
    logic [W-1:0] word;
    int unsigned mode;
    logic [W-1:0] exp_data;
    bit          exp_valid;
    bit          exp_ovr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned falls;
    int unsigned csl;
    bit seen;
    logic prev_sclk;

    reset = 1'b0; enable = 1'b0; sample_ready = 1'b0; rmode = 0;
    // mode: 0 ready low, 1 ready high, 2 ready only on capture edge, 3 random
    tbl[0] = '{1'b1, 16'hA5C3, 1, 16'hA5C3, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h1234, 0, 16'h1234, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'hBEEF, 0, 16'hBEEF, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'h0001, 0, 16'h0001, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'hFFFF, 2, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h8001, 1, 16'h8001, 1'b0, 1'b0};
    #2;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst_before) do_reset();
      run_frame(tbl[i].word, tbl[i].mode);
      chk("tbl_data",    32'(sample_data),  32'(tbl[i].exp_data));
      chk("tbl_valid",   32'(sample_valid), 32'(tbl[i].exp_valid));
      chk("tbl_overrun", 32'(overrun),      32'(tbl[i].exp_ovr));
    end

    // Reset after the 7th SCLK fall, then a clean frame.
    adc_word = 16'h7777; enable = 1'b1; rmode = 1; falls = 0; prev_sclk = spi_clock;
    for (int i = 0; i < 200 && falls < 7; i++) begin
      step();
      if (prev_sclk && !spi_clock) falls++;
      prev_sclk = spi_clock;
    end
    chk("mid_falls", falls, 7);
    do_reset();
    run_frame(16'h5A5A, 1);
    chk("post_rst_data", 32'(sample_data), 32'h5A5A);

    // Drop enable mid-frame.
    adc_word = 16'h00FF; enable = 1'b1; rmode = 1; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (m_active && cyc - m_start == 10) seen = 1;
    end
    enable = 1'b0;
    for (int i = 0; i < 100 && m_active; i++) step();
    chk("en_drop_data", 32'(sample_data), 32'h00FF);
    csl = 0;
    repeat (3 * P) begin
      step();
      if (!spi_chipselect) csl++;
    end
    chk("disabled_cs_low", csl, 0);
    enable = 1'b1; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (!spi_chipselect) seen = 1;
    end
    chk("reenable_start", 32'(seen), 32'd1);
    chk("reenable_tick",  cyc % P, 0);
    for (int i = 0; i < 100 && m_active; i++) step();

    // Random words with random ready per cycle.
    for (int i = 0; i < 6; i++) run_frame(W'($urandom), 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
